// File: rtl/sm_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the SPECIAL-function codes the core decoder uses to reach it.
package sm_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_DIVU  = 2'b01,
    MD_MTHI  = 2'b10,
    MD_MTLO  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  // MULTU and DIVU are the only ops that occupy the iterative datapath.
  function automatic logic is_arith(input logic [1:0] op);
    return (op == MD_MULTU) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/sm_muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide on a
// packed {upper, lower} accumulator. Zero latency, no flow control.
module sm_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    // Multiply: upper half accumulates the multiplicand, low half holds the
    // remaining multiplier bits; the whole pair shifts right by one.
    sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Divide: upper half is the partial remainder, low half the dividend
    // shifting out MSB-first while quotient bits shift in at the bottom.
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    fits      = rem_shift >= {1'b0, operand};
    diff      = rem_shift[WIDTH-1:0] - operand;
    if (div) begin
      acc_next = {(fits ? diff : rem_shift[WIDTH-1:0]), acc[WIDTH-2:0], fits};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sm_muldiv.sv
// Iterative unsigned MULTU/DIVU with HI/LO registers; result WIDTH cycles after accept.
// Start is accepted only while not busy; requests during busy are dropped, not queued.
module sm_muldiv
  import sm_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_e          state;
  md_state_e          state_next;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   operand;
  logic               div_mode;
  logic               accept;
  logic               last;

  assign accept = start && (state != MD_RUN);
  assign last   = (state == MD_RUN) && (cnt == CNT_W'(WIDTH - 1));

  sm_muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .div     (div_mode),
    .acc     (acc),
    .operand (operand),
    .acc_next(acc_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      MD_IDLE: begin
        if (accept && is_arith(op)) state_next = MD_RUN;
      end
      MD_RUN: begin
        busy = 1'b1;
        if (last) state_next = MD_DONE;
      end
      MD_DONE: begin
        done       = 1'b1;
        state_next = (accept && is_arith(op)) ? MD_RUN : MD_IDLE;
      end
      default: state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      operand  <= '0;
      div_mode <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      if (accept && is_arith(op)) begin
        cnt      <= '0;
        div_mode <= (op == MD_DIVU);
        // Multiply keeps the multiplier in the low half; divide keeps the dividend.
        operand  <= (op == MD_DIVU) ? srcB : srcA;
        acc      <= {{WIDTH{1'b0}}, ((op == MD_DIVU) ? srcA : srcB)};
      end else if (state == MD_RUN) begin
        cnt <= cnt + 1'b1;
        acc <= acc_next;
        if (last) begin
          hi <= acc_next[2*WIDTH-1:WIDTH];
          lo <= acc_next[WIDTH-1:0];
        end
      end
      if (accept && (op == MD_MTHI)) hi <= srcA;
      if (accept && (op == MD_MTLO)) lo <= srcA;
    end
  end

endmodule
